// File: rtl/bru_pkg.sv
// bru_pkg: shared constants and types for the execute-stage branch resolution unit.
// Rev 1.0 - initial release.
`timescale 1ns/1ps
`default_nettype none

package bru_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    REDIR = 2'd1,
    FLUSH = 2'd2
  } bru_state_e;

endpackage

`default_nettype wire

// File: rtl/bru_cond_eval.sv
// bru_cond_eval: combinational RV32I branch condition evaluation from comparator flags.
// Rev 1.0 - initial release.
`timescale 1ns/1ps
`default_nettype none

module bru_cond_eval
  import bru_pkg::*;
(
  input  logic       i_cmp_equal,
  input  logic       i_cmp_greater,
  input  logic       i_cmp_less,
  input  logic       i_rs1_msb,
  input  logic       i_rs2_msb,
  input  logic [2:0] i_funct3,
  output logic       o_taken,
  output logic       o_illegal
);

  logic w_lt_u;
  logic w_slt;

  // A well-formed comparator never raises less and greater together; greater wins if it did.
  assign w_lt_u = i_cmp_less & ~i_cmp_greater;
  assign w_slt  = (i_rs1_msb != i_rs2_msb) ? i_rs1_msb : w_lt_u;

  always_comb begin
    o_taken   = 1'b0;
    o_illegal = 1'b0;
    case (i_funct3)
      F3_BEQ:  o_taken = i_cmp_equal;
      F3_BNE:  o_taken = ~i_cmp_equal;
      F3_BLT:  o_taken = w_slt;
      F3_BGE:  o_taken = ~w_slt;
      F3_BLTU: o_taken = w_lt_u;
      F3_BGEU: o_taken = ~w_lt_u;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves branches/jumps, registers results and drives fetch redirects.
// Optional BRU_STATS_EN adds saturating branch/mispredict counters. Rev 1.0 - initial release.
`timescale 1ns/1ps
`default_nettype none

module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef BRU_STATS_EN
  input  logic            stat_clear,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_is_branch,
  input  logic            in_is_jal,
  input  logic            in_is_jalr,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_rs1,
  input  logic            cmp_equal,
  input  logic            cmp_greater,
  input  logic            cmp_less,
  input  logic            in_rs1_msb,
  input  logic            in_rs2_msb,
  input  logic            in_pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_link_pc,
  output logic            out_mispredict,
  output logic            out_illegal,
  output logic            out_misalign,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready
);

  localparam logic [2:0] c_flush_init = 3'(FLUSH_CYCLES);

  logic            w_cond_taken;
  logic            w_cond_illegal;
  logic            w_is_ctrl;
  logic            w_taken;
  logic            w_illegal;
  logic            w_misalign;
  logic            w_redirect;
  logic [XLEN-1:0] w_link;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_next_pc;
  logic            w_accept;
  logic            w_load;

  bru_state_e      r_state;
  logic [2:0]      r_flush_cnt;
  logic            r_out_valid;
  logic            r_out_taken;
  logic [XLEN-1:0] r_out_link_pc;
  logic            r_out_mispredict;
  logic            r_out_illegal;
  logic            r_out_misalign;
  logic            r_out_is_ctrl;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;

  bru_cond_eval u_cond (
    .i_cmp_equal   (cmp_equal),
    .i_cmp_greater (cmp_greater),
    .i_cmp_less    (cmp_less),
    .i_rs1_msb     (in_rs1_msb),
    .i_rs2_msb     (in_rs2_msb),
    .i_funct3      (in_funct3),
    .o_taken       (w_cond_taken),
    .o_illegal     (w_cond_illegal)
  );

  assign w_is_ctrl  = in_is_branch | in_is_jal | in_is_jalr;
  assign w_link     = in_pc + XLEN'(4);
  assign w_jalr_sum = in_rs1 + in_imm;
  assign w_target   = in_is_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : (in_pc + in_imm);
  assign w_taken    = in_is_jal | in_is_jalr | (in_is_branch & w_cond_taken);
  assign w_illegal  = in_is_branch & w_cond_illegal;
  assign w_misalign = w_taken & (w_target[1:0] != 2'b00);
  // JALR always redirects since fetch has no target prediction for it.
  assign w_redirect = w_is_ctrl & ~w_misalign & ~w_illegal &
                      ((w_taken != in_pred_taken) | in_is_jalr);
  assign w_next_pc  = w_taken ? w_target : w_link;

  assign in_ready = ((r_state == RUN) || (r_state == FLUSH)) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  // Ops accepted during FLUSH are wrong-path and are dropped here.
  assign w_load   = w_accept && (r_state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid      <= 1'b0;
      r_out_taken      <= 1'b0;
      r_out_link_pc    <= '0;
      r_out_mispredict <= 1'b0;
      r_out_illegal    <= 1'b0;
      r_out_misalign   <= 1'b0;
      r_out_is_ctrl    <= 1'b0;
    end else if (w_load) begin
      r_out_valid      <= 1'b1;
      r_out_taken      <= w_taken;
      r_out_link_pc    <= w_link;
      r_out_mispredict <= w_redirect;
      r_out_illegal    <= w_illegal;
      r_out_misalign   <= w_misalign;
      r_out_is_ctrl    <= w_is_ctrl;
    end else if (out_ready) begin
      r_out_valid      <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= RUN;
      r_flush_cnt      <= 3'd0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      if (w_load) begin
        r_redirect_pc <= w_next_pc;
      end
      case (r_state)
        RUN: begin
          if (w_load && w_redirect) begin
            r_state          <= REDIR;
            r_redirect_valid <= 1'b1;
          end
        end
        REDIR: begin
          if (redirect_ready) begin
            r_state          <= FLUSH;
            r_redirect_valid <= 1'b0;
            r_flush_cnt      <= c_flush_init;
          end
        end
        FLUSH: begin
          if (r_flush_cnt <= 3'd1) begin
            r_state     <= RUN;
            r_flush_cnt <= 3'd0;
          end else begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
          end
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign out_valid      = r_out_valid;
  assign out_taken      = r_out_taken;
  assign out_link_pc    = r_out_link_pc;
  assign out_mispredict = r_out_mispredict;
  assign out_illegal    = r_out_illegal;
  assign out_misalign   = r_out_misalign;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;

`ifdef BRU_STATS_EN
  logic        w_out_hs;
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  assign w_out_hs = r_out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_branches    <= 32'd0;
      r_stat_mispredicts <= 32'd0;
    end else if (stat_clear) begin
      r_stat_branches    <= 32'd0;
      r_stat_mispredicts <= 32'd0;
    end else if (w_out_hs) begin
      if (r_out_is_ctrl && (r_stat_branches != 32'hFFFF_FFFF)) begin
        r_stat_branches <= r_stat_branches + 32'd1;
      end
      if (r_out_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
        r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
      end
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: scoreboard bench for branch_resolve_unit (FLUSH_CYCLES=2).
// Rev 1.0 - initial release.
`timescale 1ns/1ps
`default_nettype none

module tb_branch_resolve_unit;

  typedef struct packed {
    logic        br, jal, jalr;
    logic [2:0]  f3;
    logic [31:0] pc, imm, rs1;
    logic        eq, gt, lt, m1, m2, pred;
  } op_t;

  typedef struct packed {
    logic        taken, mispredict, illegal, misalign, is_ctrl;
    logic [31:0] link, rpc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic        in_is_branch, in_is_jal, in_is_jalr;
  logic [2:0]  in_funct3;
  logic [31:0] in_pc, in_imm, in_rs1;
  logic        cmp_equal, cmp_greater, cmp_less, in_rs1_msb, in_rs2_msb, in_pred_taken;
  logic        out_valid, out_ready, out_taken, out_mispredict, out_illegal, out_misalign;
  logic [31:0] out_link_pc;
  logic        redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;
`ifdef BRU_STATS_EN
  logic        stat_clear;
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_br   = 0;
  int   exp_mp   = 0;
  exp_t sb[$];
  exp_t last_exp;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef BRU_STATS_EN
    .stat_clear       (stat_clear),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts),
`endif
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_is_branch   (in_is_branch),
    .in_is_jal      (in_is_jal),
    .in_is_jalr     (in_is_jalr),
    .in_funct3      (in_funct3),
    .in_pc          (in_pc),
    .in_imm         (in_imm),
    .in_rs1         (in_rs1),
    .cmp_equal      (cmp_equal),
    .cmp_greater    (cmp_greater),
    .cmp_less       (cmp_less),
    .in_rs1_msb     (in_rs1_msb),
    .in_rs2_msb     (in_rs2_msb),
    .in_pred_taken  (in_pred_taken),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_taken      (out_taken),
    .out_link_pc    (out_link_pc),
    .out_mispredict (out_mispredict),
    .out_illegal    (out_illegal),
    .out_misalign   (out_misalign),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic op_t mk(input int kind, input logic [2:0] f3, input logic [31:0] pc,
                             input logic [31:0] imm, input logic [31:0] rs1,
                             input logic eq, input logic gt, input logic lt,
                             input logic m1, input logic m2, input logic pred);
    op_t o;
    o.br = (kind == 1); o.jal = (kind == 2); o.jalr = (kind == 3);
    o.f3 = f3; o.pc = pc; o.imm = imm; o.rs1 = rs1;
    o.eq = eq; o.gt = gt; o.lt = lt; o.m1 = m1; o.m2 = m2; o.pred = pred;
    return o;
  endfunction

  // Reference behaviour of the RV32I resolution rules.
  function automatic exp_t model(input op_t o);
    exp_t        e;
    logic        slt, cond, ill;
    logic [31:0] tgt;
    slt  = (o.m1 != o.m2) ? o.m1 : o.lt;
    cond = 1'b0;
    ill  = 1'b0;
    case (o.f3)
      3'b000:  cond = o.eq;
      3'b001:  cond = !o.eq;
      3'b100:  cond = slt;
      3'b101:  cond = !slt;
      3'b110:  cond = o.lt;
      3'b111:  cond = !o.lt;
      default: ill  = 1'b1;
    endcase
    e.is_ctrl    = o.br | o.jal | o.jalr;
    e.illegal    = o.br & ill;
    e.taken      = o.jal | o.jalr | (o.br & cond);
    tgt          = o.jalr ? ((o.rs1 + o.imm) & 32'hFFFF_FFFE) : (o.pc + o.imm);
    e.link       = o.pc + 32'd4;
    e.misalign   = e.taken && (tgt[1:0] != 2'b00);
    e.mispredict = e.is_ctrl && !e.misalign && !e.illegal && ((e.taken != o.pred) || o.jalr);
    e.rpc        = e.taken ? tgt : e.link;
    return e;
  endfunction

  task automatic apply(input op_t o);
    in_is_branch = o.br; in_is_jal = o.jal; in_is_jalr = o.jalr;
    in_funct3 = o.f3; in_pc = o.pc; in_imm = o.imm; in_rs1 = o.rs1;
    cmp_equal = o.eq; cmp_greater = o.gt; cmp_less = o.lt;
    in_rs1_msb = o.m1; in_rs2_msb = o.m2; in_pred_taken = o.pred;
  endtask

  // Called at a negedge; returns at the negedge where the result is first visible.
  task automatic send_op(input op_t o);
    int n;
    apply(o);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", {31'd0, in_ready}, 32'd1);
    last_exp = model(o);
    sb.push_back(last_exp);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic post_check(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_redir_valid"}, {31'd0, redirect_valid}, {31'd0, last_exp.mispredict});
    check({tag, "_redir_pc"}, redirect_pc, last_exp.rpc);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic set_out_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_taken", {31'd0, out_taken}, {31'd0, e.taken});
        check("out_link_pc", out_link_pc, e.link);
        check("out_mispredict", {31'd0, out_mispredict}, {31'd0, e.mispredict});
        check("out_illegal", {31'd0, out_illegal}, {31'd0, e.illegal});
        check("out_misalign", {31'd0, out_misalign}, {31'd0, e.misalign});
        if (e.is_ctrl) exp_br++;
        if (e.mispredict) exp_mp++;
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; redirect_ready = 1'b1;
    apply(mk(0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
`ifdef BRU_STATS_EN
    stat_clear = 1'b0;
`endif
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_redir_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_link_pc", out_link_pc, 32'd0);
    check("rst_redir_pc", redirect_pc, 32'd0);
    check("rst_flags", {28'd0, out_taken, out_mispredict, out_illegal, out_misalign}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // BLT with differing signs: rs1 negative so taken, predicted not-taken
    send_op(mk(1, 3'b100, 32'h100, 32'h20, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    post_check("blt");
    idle(4);
    // BGEU taken as predicted, negative offset
    send_op(mk(1, 3'b111, 32'h200, 32'hFFFF_FFF8, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    post_check("bgeu");
    // JALR whose cleared-bit-0 target is still misaligned
    send_op(mk(3, 3'd0, 32'h300, 32'h2, 32'h1001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    post_check("jalr_mis");
    // JAL to a misaligned target
    send_op(mk(2, 3'd0, 32'h0, 32'h6, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    post_check("jal_mis");
    // Aligned JALR always redirects
    send_op(mk(3, 3'd0, 32'h380, 32'h11, 32'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    post_check("jalr");
    idle(4);
    // Back-to-back ops without redirects
    send_op(mk(2, 3'd0, 32'hFFFF_FFFC, 32'h8, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    post_check("jal_wrap");
    send_op(mk(1, 3'b010, 32'h600, 32'h40, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    post_check("illegal");
    send_op(mk(0, 3'b000, 32'h604, 32'h40, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    post_check("nonctrl");
    send_op(mk(1, 3'b001, 32'h608, 32'h40, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    post_check("bne");
    send_op(mk(1, 3'b101, 32'h60C, 32'h40, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    post_check("bge");
    send_op(mk(1, 3'b100, 32'h610, 32'h40, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    post_check("blt_same");
    send_op(mk(1, 3'b000, 32'h614, 32'h40, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    post_check("beq");
    idle(1);

    // Output backpressure holds the result and closes in_ready
    set_out_ready(1'b0);
    send_op(mk(1, 3'b000, 32'h700, 32'h40, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    post_check("bp");
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    check("bp_hold_link", out_link_pc, 32'h704);
    set_out_ready(1'b1);
    idle(1);

    // Redirect stall for 3 cycles, then 2 cycles of discarded wrong-path ops
    redirect_ready = 1'b0;
    send_op(mk(1, 3'b110, 32'h400, 32'h80, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    post_check("bltu");
    for (int i = 0; i < 3; i++) begin
      check("redir_in_ready", {31'd0, in_ready}, 32'd0);
      check("redir_hold", {31'd0, redirect_valid}, 32'd1);
      if (i < 2) @(negedge clk);
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
    check("flush_redir_valid", {31'd0, redirect_valid}, 32'd0);
    apply(mk(2, 3'd0, 32'h500, 32'h40, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    in_valid = 1'b1;
    for (int j = 0; j < 2; j++) begin
      check("flush_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b0;
    check("flush_no_redir", {31'd0, redirect_valid}, 32'd0);
    check("run_in_ready", {31'd0, in_ready}, 32'd1);
    send_op(mk(1, 3'b000, 32'h800, 32'h40, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    post_check("after_flush");
    idle(2);

`ifdef BRU_STATS_EN
    check("stat_branches", stat_branches, exp_br);
    check("stat_mispredicts", stat_mispredicts, exp_mp);
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    check("stat_clear_br", stat_branches, 32'd0);
    exp_br = 0;
    exp_mp = 0;
`endif

    // Asynchronous reset while a redirect and a held result are pending
    redirect_ready = 1'b0;
    set_out_ready(1'b0);
    send_op(mk(1, 3'b000, 32'h900, 32'h10, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    post_check("pre_rst");
    #2 rst_n = 1'b0;
    #1;
    check("arst_redir_valid", {31'd0, redirect_valid}, 32'd0);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_redir_pc", redirect_pc, 32'd0);
`ifdef BRU_STATS_EN
    check("arst_stat_br", stat_branches, 32'd0);
    check("arst_stat_mp", stat_mispredicts, 32'd0);
`endif
    sb.delete();
    exp_br = 0;
    exp_mp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    redirect_ready = 1'b1;
    @(negedge clk);
    send_op(mk(1, 3'b111, 32'hA00, 32'h20, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    post_check("post_rst");
    idle(2);
`ifdef BRU_STATS_EN
    check("final_stat_br", stat_branches, exp_br);
`endif
    check("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
